// File: rtl/matrix_inv_arbiter_pkg.sv
// Local types of the shared matrix-inverter arbiter.
package matrix_inv_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESP
  } arb_state_t;

endpackage

// File: rtl/nx_mimosa_pkg.sv
// Shared fixed-point types and constants for the IMM filter-bank datapaths.
package nx_mimosa_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned FRAC_BITS  = 16;
  localparam int unsigned STATE_DIM  = 4;

  typedef logic signed [DATA_WIDTH-1:0] fp_t;
  typedef fp_t [STATE_DIM-1:0][STATE_DIM-1:0] fp_mat_t;

  localparam fp_t FP_ONE = fp_t'(1) <<< FRAC_BITS;

  localparam int unsigned INV_TIMEOUT_DEFAULT = 64;

  // Index width for an n-entry selector; never narrower than one bit.
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nx_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or
// above ptr, wrapping to the lowest index.
module nx_rr_arbiter
  import nx_mimosa_pkg::*;
#(
  parameter int unsigned N  = 3,
  parameter int unsigned PW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic w_found;

  // First pass covers ptr..N-1, second pass the wrapped range 0..ptr-1.
  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (!w_found && req[i] && (PW'(i) >= ptr)) begin
        grant[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
    for (int i = 0; i < int'(N); i++) begin
      if (!w_found && req[i]) begin
        grant[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/matrix_inv_arbiter.sv
// Shares one 4x4 matrix inverter among N_REQ requesters: round-robin accept,
// start/wait sequencing with a watchdog, and a held response to the winner.
module matrix_inv_arbiter
  import nx_mimosa_pkg::*;
  import matrix_inv_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ       = 3,
  parameter int unsigned TIMEOUT_CYC = INV_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req_valid,
  output logic [N_REQ-1:0]  req_ready,
  input  fp_mat_t           req_mat [N_REQ],
  output logic [N_REQ-1:0]  rsp_valid,
  input  logic [N_REQ-1:0]  rsp_ready,
  output fp_mat_t           rsp_mat,
  output logic              rsp_singular,
  output logic              rsp_timeout,
  output logic              inv_start,
  output fp_mat_t           inv_A,
  input  fp_mat_t           inv_A_inv,
  input  logic              inv_done,
  input  logic              inv_singular
);

  localparam int unsigned PW = idx_w(N_REQ);
  localparam int unsigned CW = idx_w(TIMEOUT_CYC);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    r_gnt;
  logic [PW-1:0]    w_gnt_idx;
  logic [N_REQ-1:0] w_grant;
  logic [CW-1:0]    r_cnt;
  logic             w_accept;
  logic             w_done_hit;
  logic             w_to_hit;
  logic             w_rsp_hs;
  fp_mat_t          r_opnd;
  fp_mat_t          r_rsp_mat;
  logic             r_rsp_sing;
  logic             r_rsp_to;
  logic             r_start;
  logic [N_REQ-1:0] r_rsp_valid;

  nx_rr_arbiter #(
    .N  (N_REQ),
    .PW (PW)
  ) u_rr (
    .req   (req_valid),
    .ptr   (r_ptr),
    .grant (w_grant)
  );

  // Ready is only offered while idle, so at most one request is ever in flight.
  assign req_ready    = (r_state == S_IDLE) ? w_grant : '0;
  assign inv_A        = r_opnd;
  assign inv_start    = r_start;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_mat      = r_rsp_mat;
  assign rsp_singular = r_rsp_sing;
  assign rsp_timeout  = r_rsp_to;

  always_comb begin
    w_gnt_idx = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (w_grant[i]) w_gnt_idx = PW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state plus the one-cycle event strobes used by the datapath.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done_hit  = 1'b0;
    w_to_hit    = 1'b0;
    w_rsp_hs    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|(req_valid & w_grant)) begin
          w_accept    = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (inv_done) begin
          w_done_hit  = 1'b1;
          w_state_nxt = S_RESP;
        end else if (r_cnt == CW'(TIMEOUT_CYC - 1)) begin
          w_to_hit    = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready[r_gnt]) begin
          w_rsp_hs    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_cnt       <= '0;
      r_opnd      <= '0;
      r_rsp_mat   <= '0;
      r_rsp_sing  <= 1'b0;
      r_rsp_to    <= 1'b0;
      r_start     <= 1'b0;
      r_rsp_valid <= '0;
    end else begin
      r_start <= w_accept;
      if (w_accept) begin
        r_opnd <= req_mat[w_gnt_idx];
        r_gnt  <= w_gnt_idx;
      end
      if (r_state == S_START)     r_cnt <= '0;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + CW'(1);
      // A completion in the last watchdog cycle still delivers the real result.
      if (w_done_hit) begin
        r_rsp_mat  <= inv_A_inv;
        r_rsp_sing <= inv_singular;
        r_rsp_to   <= 1'b0;
      end else if (w_to_hit) begin
        r_rsp_mat  <= '0;
        r_rsp_sing <= 1'b0;
        r_rsp_to   <= 1'b1;
      end
      if (w_done_hit || w_to_hit) r_rsp_valid <= N_REQ'(1) << r_gnt;
      else if (w_rsp_hs)          r_rsp_valid <= '0;
      if (w_rsp_hs) r_ptr <= (r_gnt == PW'(N_REQ - 1)) ? '0 : r_gnt + PW'(1);
    end
  end

endmodule

// File: tb/tb_matrix_inv_arbiter.sv
// Bench for matrix_inv_arbiter: stand-in inverter, transaction-level reference
// model checked every cycle, directed scenarios plus randomized traffic.
module tb_matrix_inv_arbiter;
  import nx_mimosa_pkg::*;

  localparam int N       = 3;
  localparam int TO      = 64;
  localparam int LAT_INV = 21;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  fp_mat_t      req_mat [N];
  fp_mat_t      rsp_mat, inv_A, inv_A_inv;
  logic         rsp_singular, rsp_timeout, inv_start, inv_done, inv_singular;
  logic         model_done, stray_done, inv_hang;

  assign inv_done = model_done | stray_done;

  matrix_inv_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_mat      (req_mat),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_mat      (rsp_mat),
    .rsp_singular (rsp_singular),
    .rsp_timeout  (rsp_timeout),
    .inv_start    (inv_start),
    .inv_A        (inv_A),
    .inv_A_inv    (inv_A_inv),
    .inv_done     (inv_done),
    .inv_singular (inv_singular)
  );

  // Stand-in inverse: exact for diagonal operands, a fixed transform elsewhere.
  function automatic fp_mat_t ref_inv(fp_mat_t a);
    fp_mat_t r;
    fp_t e;
    logic signed [63:0] num, d;
    num = 64'sd1 <<< (2 * FRAC_BITS);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        e = a[i][j];
        if (i == j) begin
          d = e;
          r[i][j] = (e == 0) ? fp_t'(0) : fp_t'(num / d);
        end else begin
          r[i][j] = -e;
        end
      end
    return r;
  endfunction

  function automatic logic ref_sing(fp_mat_t a);
    fp_t e;
    logic s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e = a[i][i];
      if (e == 0) s = 1'b1;
    end
    return s;
  endfunction

  function automatic fp_mat_t rand_mat(int kind);
    fp_mat_t m;
    fp_t e;
    int k;
    m = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        e = fp_t'($urandom);
        if (kind == 0) e = (i == j) ? fp_t'($urandom_range(32'h4000, 32'h80000)) : fp_t'(0);
        else if (i == j && e == 0) e = FP_ONE;
        m[i][j] = e;
      end
    if (kind == 2) begin
      k = $urandom_range(0, 3);
      m[k][k] = '0;
    end
    return m;
  endfunction

  // Inverter stand-in: samples A the cycle after start, done LAT_INV cycles after start.
  int      inv_cnt;
  logic    inv_busy;
  fp_mat_t a_smp;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_busy     <= 1'b0;
      inv_cnt      <= 0;
      model_done   <= 1'b0;
      inv_A_inv    <= '0;
      inv_singular <= 1'b0;
      a_smp        <= '0;
    end else begin
      model_done <= 1'b0;
      if (inv_start && !inv_hang) begin
        inv_busy <= 1'b1;
        inv_cnt  <= 1;
      end else if (inv_busy) begin
        inv_cnt <= inv_cnt + 1;
        if (inv_cnt == 1) a_smp <= inv_A;
        if (inv_cnt == LAT_INV - 1) begin
          model_done   <= 1'b1;
          inv_A_inv    <= ref_inv(a_smp);
          inv_singular <= ref_sing(a_smp);
          inv_busy     <= 1'b0;
        end
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(string name, logic [511:0] got, logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Transaction-level reference state.
  logic    m_busy = 1'b0, m_known = 1'b0, m_sing = 1'b0, m_to = 1'b0;
  int      m_ptr = 0, m_owner = 0, m_acc = 0, m_rsp_cyc = 0;
  fp_mat_t m_opnd = '0, m_mat = '0;
  int      obs_acc = 0;
  int      glog[$];

  // One clock cycle: compare outputs with the model, log handshakes, advance the model.
  task automatic step();
    logic [N-1:0] e_rdy, e_rv, hs;
    int idx;
    #1;
    if (!rst_n) begin
      m_busy = 1'b0; m_known = 1'b0; m_ptr = 0; m_opnd = '0;
    end
    e_rdy = '0;
    if (!m_busy)
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (req_valid[idx] && e_rdy == '0) e_rdy[idx] = 1'b1;
      end
    e_rv = (m_busy && m_known && cyc >= m_rsp_cyc) ? (N'(1) << m_owner) : '0;
    chk("req_ready", 512'(req_ready), 512'(e_rdy));
    chk("inv_start", 512'(inv_start), 512'(m_busy && cyc == m_acc + 1));
    chk("rsp_valid", 512'(rsp_valid), 512'(e_rv));
    chk("inv_A", 512'(inv_A), 512'(m_opnd));
    if (e_rv != 0) begin
      chk("rsp_mat", 512'(rsp_mat), 512'(m_mat));
      chk("rsp_singular", 512'(rsp_singular), 512'(m_sing));
      chk("rsp_timeout", 512'(rsp_timeout), 512'(m_to));
    end else if (!rst_n) begin
      chk("rst_rsp_mat", 512'(rsp_mat), 512'(0));
      chk("rst_flags", 512'({rsp_singular, rsp_timeout}), 512'(0));
    end
    hs = req_valid & req_ready;
    if (rst_n && hs != 0) begin
      obs_acc = cyc;
      for (int k = 0; k < N; k++) if (hs[k]) glog.push_back(k);
    end
    if (rst_n) begin
      if (e_rv != 0 && rsp_ready[m_owner]) begin
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % N;
      end else if (m_busy && !m_known) begin
        if (inv_done && cyc >= m_acc + 2) begin
          m_known = 1'b1; m_rsp_cyc = cyc + 1;
          m_mat = ref_inv(m_opnd); m_sing = ref_sing(m_opnd); m_to = 1'b0;
        end else if (cyc == m_acc + 1 + TO) begin
          m_known = 1'b1; m_rsp_cyc = cyc + 1;
          m_mat = '0; m_sing = 1'b0; m_to = 1'b1;
        end
      end else if (!m_busy && e_rdy != 0) begin
        for (int k = 0; k < N; k++) if (e_rdy[k]) m_owner = k;
        m_busy = 1'b1; m_known = 1'b0; m_acc = cyc; m_opnd = req_mat[m_owner];
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_rsp(int max);
    int n = 0;
    while (rsp_valid == 0 && n < max) begin
      step();
      n++;
    end
    chk("rsp_arrived", 512'(rsp_valid != 0), 512'(1));
  endtask

  task automatic finish_rsp(logic [N-1:0] rdy);
    rsp_ready = rdy;
    step();
    rsp_ready = '0;
    step();
  endtask

  fp_mat_t half_diag;
  int      exp_order[6] = '{0, 1, 2, 0, 1, 2};
  int      n_before, n;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running at cycle %0d, required finish", cyc);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = '0; rsp_ready = '0; stray_done = 1'b0; inv_hang = 1'b0;
    for (int k = 0; k < N; k++) req_mat[k] = '0;
    half_diag = '0;
    for (int i = 0; i < 4; i++) half_diag[i][i] = 32'sh0000_8000;
    @(negedge clk);
    step(); step();
    rst_n = 1'b1;
    step();

    // Contention: all requesters valid, responses consumed immediately.
    for (int k = 0; k < N; k++) req_mat[k] = rand_mat(0);
    glog.delete();
    req_valid = '1; rsp_ready = '1;
    n = 0;
    while (glog.size() < 6 && n < 400) begin step(); n++; end
    req_valid = '0;
    repeat (30) step();
    rsp_ready = '0;
    chk("grant_count", 512'(glog.size()), 512'(6));
    for (int k = 0; k < 6 && k < glog.size(); k++)
      chk("grant_order", 512'(glog[k]), 512'(exp_order[k]));

    // Single request, diag(2.0).
    req_mat[1] = '0;
    for (int i = 0; i < 4; i++) req_mat[1][i][i] = 32'sh0002_0000;
    req_valid = 3'b010;
    step();
    req_valid = '0;
    wait_rsp(100);
    chk("single_latency", 512'(cyc - obs_acc), 512'(23));
    chk("single_rsp_valid", 512'(rsp_valid), 512'(3'b010));
    chk("single_rsp_mat", 512'(rsp_mat), 512'(half_diag));
    chk("single_singular", 512'(rsp_singular), 512'(0));
    finish_rsp(3'b010);

    // Singular operand.
    req_mat[0] = '0;
    req_valid = 3'b001;
    step();
    req_valid = '0;
    wait_rsp(100);
    chk("sing_flag", 512'(rsp_singular), 512'(1));
    chk("sing_timeout", 512'(rsp_timeout), 512'(0));
    finish_rsp(3'b001);
    req_valid = 3'b100;
    #1 chk("idle_after_sing", 512'(req_ready), 512'(3'b100));
    req_valid = '0;
    step();

    // Watchdog: inverter never completes; a late done is ignored.
    inv_hang = 1'b1;
    req_mat[1] = rand_mat(1);
    req_valid = 3'b010;
    step();
    req_valid = '0;
    wait_rsp(200);
    chk("to_latency", 512'(cyc - obs_acc), 512'(66));
    chk("to_flag", 512'(rsp_timeout), 512'(1));
    chk("to_rsp_mat", 512'(rsp_mat), 512'(0));
    repeat (5) step();
    stray_done = 1'b1;
    step();
    stray_done = 1'b0;
    repeat (3) step();
    chk("to_held_after_stray", 512'({rsp_valid, rsp_timeout}), 512'({3'b010, 1'b1}));
    finish_rsp(3'b010);
    inv_hang = 1'b0;
    stray_done = 1'b1;
    step();
    stray_done = 1'b0;
    step();

    // Backpressure on requester 0 with requester 2 waiting.
    req_mat[0] = rand_mat(1);
    req_mat[2] = rand_mat(0);
    req_valid = 3'b001;
    step();
    req_valid = 3'b100;
    wait_rsp(100);
    n_before = glog.size();
    rsp_ready = 3'b110;
    repeat (10) step();
    chk("bp_no_accept", 512'(glog.size()), 512'(n_before));
    chk("bp_rsp_held", 512'(rsp_valid), 512'(3'b001));
    rsp_ready = 3'b001;
    step();
    rsp_ready = '0;
    #1 chk("bp_next_ready", 512'(req_ready), 512'(3'b100));
    step();
    chk("bp_next_grant", 512'(glog[glog.size()-1]), 512'(2));
    req_valid = '0;
    wait_rsp(100);
    finish_rsp(3'b100);

    // Reset during S_WAIT.
    req_mat[1] = rand_mat(0);
    req_valid = 3'b010;
    step();
    req_valid = '0;
    repeat (10) step();
    rst_n = 1'b0;
    #1 chk("rst_outputs", 512'({inv_A, rsp_valid, inv_start}), 512'(0));
    step(); step();
    rst_n = 1'b1;
    req_mat[0] = rand_mat(0);
    req_valid = 3'b111;
    #1 chk("rst_ptr_zero", 512'(req_ready), 512'(3'b001));
    step();
    req_valid = '0;
    wait_rsp(100);
    chk("rst_then_latency", 512'(cyc - obs_acc), 512'(23));
    chk("rst_then_rsp", 512'(rsp_valid), 512'(3'b001));
    finish_rsp(3'b001);

    // Randomized traffic.
    for (int t = 0; t < 2500; t++) begin
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 7) == 0) req_mat[k] = rand_mat($urandom_range(0, 2));
      req_valid = N'($urandom);
      rsp_ready = N'($urandom);
      step();
    end
    req_valid = '0;
    rsp_ready = '1;
    repeat (40) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_inv_arbiter.md
Name: matrix_inv_arbiter

Overview:
- Shares one matrix_inverse_4x4 datapath among N_REQ requesters, e.g. the per-model innovation-covariance inversions of the IMM filter bank.
- Arbitrates requests round-robin and captures the winning matrix.
- Sequences the inverter (start pulse, stable operand, wait for done), then returns the inverse and status to the winner.
- A watchdog guarantees that every accepted request gets a response.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- TIMEOUT_CYC, 64, maximum cycles from inv_start to inv_done before the request is aborted.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  [N_REQ]  requester i has a matrix to invert.
- req_ready  out  [N_REQ]  one-hot; request accepted when req_valid[i] and req_ready[i] are both high.
- req_mat  in  [N_REQ] x fp_t[STATE_DIM][STATE_DIM]  per-requester operand.
- rsp_valid  out  [N_REQ]  one-hot; result available for requester i.
- rsp_ready  in  [N_REQ]  requester i consumes the result.
- rsp_mat  out  fp_t[STATE_DIM][STATE_DIM]  inverse, shared by all requesters, qualified by rsp_valid.
- rsp_singular  out  1  inverter flagged singular.
- rsp_timeout  out  1  watchdog expired; rsp_mat is all zeros.
- inv_start  out  1  single-cycle start to the inverter.
- inv_A  out  fp_t[STATE_DIM][STATE_DIM]  operand; held stable from inv_start until inv_done.
- inv_A_inv  in  fp_t[STATE_DIM][STATE_DIM]  inverter result.
- inv_done  in  1  inverter completion pulse.
- inv_singular  in  1  inverter singular flag, valid while inv_done is high.

Behaviour:
- Reset values:
  - all outputs zero;
  - state S_IDLE;
  - round-robin pointer = 0 (requester 0 highest priority);
  - operand and result registers zero.
- FSM states: S_IDLE, S_START, S_WAIT, S_RESP.
- S_IDLE:
  - grant g = first i with req_valid[i], searching from the pointer upward and wrapping modulo N_REQ.
  - req_ready[g] = 1, combinationally from req_valid, only in S_IDLE; all other req_ready bits are 0.
  - On handshake: latch req_mat[g] into the operand register, store g, go to S_START.
  - With no request: stay in S_IDLE.
- S_START: inv_start = 1 for exactly one cycle; clear the watchdog counter; go to S_WAIT.
- S_WAIT:
  - Counter increments every cycle.
  - When inv_done = 1: capture inv_A_inv into rsp_mat and inv_singular into rsp_singular; rsp_timeout = 0; go to S_RESP.
  - When counter reaches TIMEOUT_CYC-1 without inv_done: rsp_mat = 0, rsp_singular = 0, rsp_timeout = 1; go to S_RESP.
  - If inv_done and the timeout occur in the same cycle, inv_done wins.
- S_RESP:
  - rsp_valid[g] = 1 (registered); it holds, together with rsp_mat and the flags, until rsp_ready[g] = 1.
  - rsp_ready bits of non-granted requesters are ignored.
  - On handshake: pointer = (g+1) mod N_REQ; go to S_IDLE.
  - Next accept is no earlier than the cycle after the response handshake; there is no overlap of requests.
- inv_A is driven from the operand register at all times and changes only on an accept.
  - The inverter samples A in its own init cycle, one cycle after inv_start; stability through completion is mandatory.
- Latency: the inverter completes 21 cycles after inv_start. Total from accept to rsp_valid is 23 cycles. The arbiter must not hard-code either figure.
- A stray inv_done outside S_WAIT (e.g. a late completion after a timeout) is ignored and does not change state.
- A requester dropping req_valid before being granted is legal; it is simply not served.
- Fairness: with all requesters continuously valid, grants cycle 0,1,...,N_REQ-1,0. No starvation; each requester waits at most N_REQ-1 transactions.
- Reset asserted mid-operation:
  - immediate return to reset values;
  - the pending request is dropped with no response;
  - the inverter is reset by the same rst_n.

Decomposition:
- Shared package (nx_mimosa_pkg): fp_t, STATE_DIM, DATA_WIDTH, FP_ONE, plus a new typedef fp_mat_t (fp_t[STATE_DIM][STATE_DIM]) and constant INV_TIMEOUT_DEFAULT = 64.
- Local: arb_state_t enum.
- One natural sub-module: nx_rr_arbiter (parameter N; inputs req[N], ptr; output one-hot grant), purely combinational, reusable by other shared-resource controllers.
- The inverter itself is instantiated beside this block at the top level, not inside it.

Test Plan:
- Single request, diagonal operand: req 1 with diag(2.0) -> inv_start one cycle after accept; rsp_valid[1] 23 cycles after accept; rsp_mat diagonal 0.5 ± 2 LSB; rsp_singular = 0.
- Contention: req_valid = 3'b111 held, rsp_ready tied high -> grant order 0,1,2,0,1,2; exactly one req_ready bit high per accept; inv_A never changes between inv_start and inv_done.
- Singular operand: all-zero matrix -> rsp_singular = 1; rsp_timeout = 0; arbiter returns to S_IDLE after rsp_ready.
- Timeout: inverter model never pulses inv_done -> rsp_valid after TIMEOUT_CYC in S_WAIT with rsp_timeout = 1 and rsp_mat = 0; a late inv_done injected 5 cycles later is ignored.
- Backpressure: rsp_ready[0] held low for 10 cycles -> rsp_valid[0] and rsp_mat stable throughout; a pending req 2 is not accepted until the response handshake completes.
- Reset mid-S_WAIT: rst_n low for 2 cycles -> all outputs 0 immediately, pointer 0; a subsequent request from requester 0 is served normally.
